// File: rtl/npc_bus_pkg.sv
// Shared definitions for the core-to-data-bus bridge: FSM encoding, strobe width
// and word-alignment helpers.
package npc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } bridge_state_e;

  localparam int BUS_STRB_W = 4;

  localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

  // The bus only accepts word-aligned addresses; sub-word selection is done downstream.
  function automatic logic [31:0] alignWord(input logic [31:0] addr);
    return addr & ADDR_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Cycle counter bounding the time a bridge access may spend on the bus.
// A TIMEOUT_CYCLES of 0 disables expiry entirely.
module bus_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [CNT_W-1:0] count_q;

  // Count busy cycles and saturate on the last one so expiry stays asserted until cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && (count_q != CNT_LAST)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expired = (TIMEOUT_CYCLES > 0) && (count_q == CNT_LAST);

endmodule

// File: rtl/dmem_bridge.sv
// Turns the core's single-cycle data-memory access into a valid/ready bus
// transaction, stalling the core until the response (or a timeout) completes it.
// Responses that arrive outside the wait phase are recorded in a sticky flag.
module dmem_bridge
  import npc_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_wen,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [7:0]            req_wmask,
  output logic                  stall,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  done,
  output logic                  stray_rsp,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [31:0]           mem_req_addr,
  output logic                  mem_req_wen,
  output logic [31:0]           mem_req_wdata,
  output logic [BUS_STRB_W-1:0] mem_req_wstrb,
  input  logic                  mem_rsp_valid,
  input  logic [31:0]           mem_rsp_rdata,
  input  logic                  mem_rsp_err
);

  bridge_state_e         state_q;
  logic                  reqWen_q;
  logic [31:0]           reqAddr_q;
  logic [31:0]           reqWdata_q;
  logic [BUS_STRB_W-1:0] reqWstrb_q;
  logic                  memReqValid_q;
  logic                  done_q;
  logic [31:0]           rspRdata_q;
  logic                  rspErr_q;
  logic                  stray_q;

  logic tmoClr;
  logic tmoEn;
  logic tmoExpired;

  // Only the low strobe bits reach the bus; the upper mask bits are don't-care.
  logic unused_wmaskHi;
  assign unused_wmaskHi = ^req_wmask[7:BUS_STRB_W];

  // The timeout window opens when a request is accepted from the core and
  // covers every cycle spent presenting the request or waiting for its response.
  assign tmoClr = (state_q == ST_IDLE) && req_valid;
  assign tmoEn  = (state_q == ST_REQ) || (state_q == ST_WAIT);

  bus_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmoClr),
    .en     (tmoEn),
    .expired(tmoExpired)
  );

  // Access sequencing: latch the core request, present it until accepted, wait for
  // the response (or give up on timeout), then release the core for one commit cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      reqWen_q      <= 1'b0;
      reqAddr_q     <= '0;
      reqWdata_q    <= '0;
      reqWstrb_q    <= '0;
      memReqValid_q <= 1'b0;
      done_q        <= 1'b0;
      rspRdata_q    <= '0;
      rspErr_q      <= 1'b0;
      stray_q       <= 1'b0;
    end else begin
      if (mem_rsp_valid && (state_q != ST_WAIT)) begin
        stray_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            reqWen_q      <= req_wen;
            reqAddr_q     <= alignWord(req_addr);
            reqWdata_q    <= req_wdata;
            reqWstrb_q    <= req_wen ? req_wmask[BUS_STRB_W-1:0] : '0;
            memReqValid_q <= 1'b1;
            state_q       <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (mem_req_ready) begin
            memReqValid_q <= 1'b0;
            state_q       <= ST_WAIT;
          end else if (tmoExpired) begin
            memReqValid_q <= 1'b0;
            rspRdata_q    <= '0;
            rspErr_q      <= 1'b1;
            done_q        <= 1'b1;
            state_q       <= ST_DONE;
          end
        end

        ST_WAIT: begin
          if (mem_rsp_valid) begin
            rspRdata_q <= mem_rsp_rdata;
            rspErr_q   <= mem_rsp_err;
            done_q     <= 1'b1;
            state_q    <= ST_DONE;
          end else if (tmoExpired) begin
            rspRdata_q <= '0;
            rspErr_q   <= 1'b1;
            done_q     <= 1'b1;
            state_q    <= ST_DONE;
          end
        end

        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          memReqValid_q <= 1'b0;
          done_q        <= 1'b0;
          state_q       <= ST_IDLE;
        end
      endcase
    end
  end

  // The core must freeze in the very cycle it presents an access, so the idle
  // term of the stall is taken straight from req_valid.
  always_comb begin
    stall = 1'b0;
    case (state_q)
      ST_IDLE: stall = req_valid;
      ST_REQ:  stall = 1'b1;
      ST_WAIT: stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  assign done          = done_q;
  assign rsp_rdata     = rspRdata_q;
  assign rsp_err       = rspErr_q;
  assign stray_rsp     = stray_q;
  assign mem_req_valid = memReqValid_q;
  assign mem_req_addr  = reqAddr_q;
  assign mem_req_wen   = reqWen_q;
  assign mem_req_wdata = reqWdata_q;
  assign mem_req_wstrb = reqWstrb_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed scenarios plus randomized bus
// latencies, checked against a per-access timing model derived from the
// ready delay, response delay and timeout limit.
module tb_dmem_bridge;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        stall;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        done;
  logic        stray_rsp;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        mem_rsp_err;

  int          total = 0;
  int          bad = 0;
  int          acceptCount = 0;
  logic        strayExp = 1'b0;
  logic [31:0] lastRdata = 32'h0;
  logic        lastErr = 1'b0;

  dmem_bridge #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_wen      (req_wen),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_wmask    (req_wmask),
    .stall        (stall),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .done         (done),
    .stray_rsp    (stray_rsp),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_req_wen  (mem_req_wen),
    .mem_req_wdata(mem_req_wdata),
    .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata),
    .mem_rsp_err  (mem_rsp_err)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Count bus handshakes so back-to-back instructions can be checked for request count.
  always @(posedge clk) begin
    if (!rst && mem_req_valid && mem_req_ready) acceptCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete core access. Called at a negedge with the bridge idle; returns at
  // the negedge of the idle cycle that follows DONE.
  task automatic applyStimulus(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [7:0] wmask, input int readyDelay, input int rspDelay,
                               input logic [31:0] busData, input logic busErr, input bit keepValid);
    int          reqEnd;
    int          rspK;
    int          endK;
    int          limit;
    bit          timedOut;
    logic [31:0] expAddr;
    logic [3:0]  expStrb;
    logic [31:0] expRdata;
    logic        expErr;

    expAddr = {addr[31:2], 2'b00};
    expStrb = wen ? wmask[3:0] : 4'h0;
    if (readyDelay > TMO - 1) begin
      reqEnd   = TMO - 1;
      rspK     = -1;
      endK     = TMO - 1;
      timedOut = 1'b1;
    end else begin
      reqEnd = readyDelay;
      rspK   = readyDelay + 1 + rspDelay;
      limit  = (TMO - 1 > readyDelay + 1) ? TMO - 1 : readyDelay + 1;
      if (rspK <= limit) begin
        endK     = rspK;
        timedOut = 1'b0;
      end else begin
        endK     = limit;
        timedOut = 1'b1;
      end
    end
    expRdata = timedOut ? 32'h0 : busData;
    expErr   = timedOut ? 1'b1 : busErr;

    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    #1;
    checkOutput("idle_stall", {31'b0, stall}, 32'd1);
    checkOutput("idle_reqvalid", {31'b0, mem_req_valid}, 32'd0);
    checkOutput("idle_done", {31'b0, done}, 32'd0);
    @(posedge clk);

    for (int k = 0; k <= endK; k++) begin
      @(negedge clk);
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_wmask = 8'($urandom);
      req_wen   = 1'($urandom);
      checkOutput("busy_stall", {31'b0, stall}, 32'd1);
      checkOutput("busy_done", {31'b0, done}, 32'd0);
      checkOutput("busy_reqvalid", {31'b0, mem_req_valid}, (k <= reqEnd) ? 32'd1 : 32'd0);
      if (k <= reqEnd) begin
        checkOutput("req_addr", mem_req_addr, expAddr);
        checkOutput("req_wdata", mem_req_wdata, wdata);
        checkOutput("req_wstrb", {28'b0, mem_req_wstrb}, {28'b0, expStrb});
        checkOutput("req_wen", {31'b0, mem_req_wen}, {31'b0, wen});
      end
      mem_req_ready = (k == readyDelay);
      mem_rsp_valid = (k == rspK);
      mem_rsp_rdata = (k == rspK) ? busData : $urandom;
      mem_rsp_err   = (k == rspK) ? busErr : 1'($urandom);
      @(posedge clk);
    end

    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = $urandom;
    mem_rsp_err   = 1'($urandom);
    #1;
    checkOutput("done_pulse", {31'b0, done}, 32'd1);
    checkOutput("done_stall", {31'b0, stall}, 32'd0);
    checkOutput("done_reqvalid", {31'b0, mem_req_valid}, 32'd0);
    checkOutput("done_rdata", rsp_rdata, expRdata);
    checkOutput("done_err", {31'b0, rsp_err}, {31'b0, expErr});
    checkOutput("done_stray", {31'b0, stray_rsp}, {31'b0, strayExp});
    lastRdata = expRdata;
    lastErr   = expErr;
    if (!keepValid) req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("after_done", {31'b0, done}, 32'd0);
    checkOutput("after_reqvalid", {31'b0, mem_req_valid}, 32'd0);
    if (!keepValid) checkOutput("after_stall", {31'b0, stall}, 32'd0);
  endtask

  // A bus response while the bridge is idle must raise the sticky flag and not be captured.
  task automatic lateResponse();
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = $urandom;
    mem_rsp_err   = 1'($urandom);
    @(posedge clk);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    strayExp = 1'b1;
    #1;
    checkOutput("stray_set", {31'b0, stray_rsp}, 32'd1);
    checkOutput("stray_hold_rdata", rsp_rdata, lastRdata);
    checkOutput("stray_hold_err", {31'b0, rsp_err}, {31'b0, lastErr});
  endtask

  initial begin
    int a0;
    int r;
    logic w;

    rst           = 1'b1;
    req_valid     = 1'b0;
    req_wen       = 1'b0;
    req_addr      = '0;
    req_wdata     = '0;
    req_wmask     = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    mem_rsp_err   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_stall", {31'b0, stall}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    checkOutput("rst_rdata", rsp_rdata, 32'h0);
    checkOutput("rst_err", {31'b0, rsp_err}, 32'd0);
    checkOutput("rst_stray", {31'b0, stray_rsp}, 32'd0);
    checkOutput("rst_reqvalid", {31'b0, mem_req_valid}, 32'd0);
    checkOutput("rst_addr", mem_req_addr, 32'h0);
    checkOutput("rst_wdata", mem_req_wdata, 32'h0);
    checkOutput("rst_wstrb", {28'b0, mem_req_wstrb}, 32'h0);
    checkOutput("rst_wen", {31'b0, mem_req_wen}, 32'd0);

    $display("[TB] zero-wait load");
    applyStimulus(1'b0, 32'h8000_0006, 32'h0, 8'hFF, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);

    $display("[TB] store with backpressure");
    applyStimulus(1'b1, 32'h1000_0010, 32'h1234_5678, 8'h0C, 3, 0, 32'h5555_AAAA, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h2000_0003, 32'hCAFE_F00D, 8'hF3, 1, 2, 32'h0BAD_0BAD, 1'b0, 1'b0);

    $display("[TB] bus error then clean access");
    applyStimulus(1'b0, 32'h0000_0100, 32'h0, 8'h00, 0, 1, 32'h1111_2222, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0000_0104, 32'h0, 8'h00, 0, 0, 32'h3333_4444, 1'b0, 1'b0);

    $display("[TB] response coincides with timeout, then wait timeout");
    applyStimulus(1'b0, 32'h0000_0200, 32'h0, 8'h00, 0, TMO - 2, 32'h7777_8888, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0000_0204, 32'h0, 8'h00, 0, TMO - 1, 32'h9999_AAAA, 1'b0, 1'b0);

    $display("[TB] request timeout and late response");
    applyStimulus(1'b1, 32'h0000_0300, 32'hFFFF_0000, 8'h0F, 100, 0, 32'h0, 1'b0, 1'b0);
    lateResponse();

    $display("[TB] reset mid-wait");
    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 32'h4000_0008;
    req_wdata = 32'hA5A5_A5A5;
    req_wmask = 8'h0F;
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    req_valid     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_stall", {31'b0, stall}, 32'd0);
    checkOutput("midrst_done", {31'b0, done}, 32'd0);
    checkOutput("midrst_reqvalid", {31'b0, mem_req_valid}, 32'd0);
    checkOutput("midrst_stray", {31'b0, stray_rsp}, 32'd0);
    checkOutput("midrst_rdata", rsp_rdata, 32'h0);
    checkOutput("midrst_err", {31'b0, rsp_err}, 32'd0);
    checkOutput("midrst_addr", mem_req_addr, 32'h0);
    checkOutput("midrst_wdata", mem_req_wdata, 32'h0);
    checkOutput("midrst_wstrb", {28'b0, mem_req_wstrb}, 32'h0);
    checkOutput("midrst_wen", {31'b0, mem_req_wen}, 32'd0);
    strayExp  = 1'b0;
    lastRdata = 32'h0;
    lastErr   = 1'b0;
    applyStimulus(1'b0, 32'h4000_0009, 32'h0, 8'h00, 1, 1, 32'h0123_4567, 1'b0, 1'b0);

    $display("[TB] req_valid held across two instructions");
    a0 = acceptCount;
    applyStimulus(1'b0, 32'h5000_0000, 32'h0, 8'h00, 0, 0, 32'hFEED_0001, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h5000_0004, 32'h7654_3210, 8'h03, 0, 0, 32'hFEED_0002, 1'b0, 1'b0);
    checkOutput("held_accepts", 32'(acceptCount - a0), 32'd2);

    $display("[TB] randomized accesses");
    for (int i = 0; i < 24; i++) begin
      r = ($urandom_range(0, 7) == 0) ? TMO + 2 : int'($urandom_range(0, 4));
      w = 1'($urandom);
      applyStimulus(w, $urandom, $urandom, 8'($urandom), r, int'($urandom_range(0, 5)),
                    $urandom, 1'($urandom), 1'b0);
      if (r > TMO - 1 && $urandom_range(0, 1) == 1) lateResponse();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
